// File: rtl/sign_add_sub_sched_pkg.sv
// sign_add_sub_sched_pkg
//   Shared definitions for the add/sub scheduler: FSM state encoding,
//   unit mode encoding and the signed-overflow helper.
//   Overflow logic is only instantiated when SIGN_ADD_SUB_SCHED_OVERFLOW_EN
//   is defined.
package sign_add_sub_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Two's-complement overflow from operand/result sign bits.
   // add: operands agree in sign, result disagrees.
   // sub: operands disagree in sign, result disagrees with A.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic r_msb,
                                       input logic mode);
      if (mode == MODE_SUB) begin
         return (a_msb ^ b_msb) & (r_msb ^ a_msb);
      end
      return ~(a_msb ^ b_msb) & (r_msb ^ a_msb);
   endfunction

endpackage

// File: rtl/sign_add_sub_sched_rr_pick_first.sv
// rr_pick_first
//   Combinational round-robin finder: returns the first asserted bit of
//   req_i searching ptr_i, ptr_i+1, ... modulo NUM_REQ.
// Ports:
//   req_i   [NUM_REQ-1:0]  request vector
//   ptr_i   [PW-1:0]       search start (priority pointer)
//   found_o                at least one request asserted
//   idx_o   [PW-1:0]       index of the selected request (0 if none)
module rr_pick_first #(
   parameter int NUM_REQ = 4,
   parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic               found_o,
   output logic [PW-1:0]      idx_o
);

   logic [PW-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PW'((int'(ptr_i) + k) % NUM_REQ);
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/sign_add_sub_sched.sv
// sign_add_sub_sched
//   Round-robin scheduler sharing one signed add/sub unit among NUM_REQ
//   requesters. An accepted request drives the unit operands, the result is
//   captured after UNIT_LATENCY cycles and returned on a response handshake.
//   Optional macro SIGN_ADD_SUB_SCHED_OVERFLOW_EN enables RspOverflow; when
//   undefined RspOverflow is tied to 0.
// Ports:
//   Clk, ResetN (async, active low)
//   ReqValid/ReqReady/ReqA/ReqB/ReqMode   request side (A/B packed per slice)
//   RspValid/RspReady/RspData/RspOverflow response side (shared data bus)
//   UnitA/UnitB/UnitMode -> shared unit, UnitResult <- shared unit
module sign_add_sub_sched
   import sign_add_sub_sched_pkg::*;
#(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int NUM_REQ         = 4,
   parameter int UNIT_LATENCY    = 1
) (
   input  logic                               Clk,
   input  logic                               ResetN,
   input  logic [NUM_REQ-1:0]                 ReqValid,
   output logic [NUM_REQ-1:0]                 ReqReady,
   input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] ReqA,
   input  logic [NUM_REQ*INPUT_BIT_WIDTH-1:0] ReqB,
   input  logic [NUM_REQ-1:0]                 ReqMode,
   output logic [NUM_REQ-1:0]                 RspValid,
   input  logic [NUM_REQ-1:0]                 RspReady,
   output logic [INPUT_BIT_WIDTH-1:0]         RspData,
   output logic                               RspOverflow,
   output logic [INPUT_BIT_WIDTH-1:0]         UnitA,
   output logic [INPUT_BIT_WIDTH-1:0]         UnitB,
   output logic                               UnitMode,
   input  logic [INPUT_BIT_WIDTH-1:0]         UnitResult
);

   localparam int W  = INPUT_BIT_WIDTH;
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(UNIT_LATENCY + 1);

   state_e            state_q;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     grant_q;
   logic [CW-1:0]     cnt_q;
   logic [W-1:0]      unit_a_q;
   logic [W-1:0]      unit_b_q;
   logic              unit_mode_q;
   logic [W-1:0]      rsp_data_q;
   logic [NUM_REQ-1:0] rsp_valid_q;

   logic              pick_found;
   logic [PW-1:0]     pick_idx;
   logic              accept;
   logic              capture;

   rr_pick_first #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
      .req_i   (ReqValid),
      .ptr_i   (ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // ReqReady is combinational from the finder; gating with ResetN keeps it
   // low while reset is held even though the state register reads IDLE.
   assign accept   = ResetN && (state_q == IDLE) && pick_found;
   assign ReqReady = accept ? (NUM_REQ'(1) << pick_idx) : '0;
   assign capture  = (state_q == WAIT) && (cnt_q == CW'(1));

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         cnt_q       <= '0;
         unit_a_q    <= '0;
         unit_b_q    <= '0;
         unit_mode_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  unit_a_q    <= ReqA[pick_idx*W +: W];
                  unit_b_q    <= ReqB[pick_idx*W +: W];
                  unit_mode_q <= ReqMode[pick_idx];
                  grant_q     <= pick_idx;
                  cnt_q       <= CW'(UNIT_LATENCY);
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CW'(1);
               if (capture) begin
                  rsp_data_q  <= UnitResult;
                  rsp_valid_q <= NUM_REQ'(1) << grant_q;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (RspReady[grant_q]) begin
                  rsp_valid_q <= '0;
                  ptr_q       <= (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + PW'(1);
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SIGN_ADD_SUB_SCHED_OVERFLOW_EN
   logic rsp_ovf_d;
   logic rsp_ovf_q;

   assign rsp_ovf_d = signed_ovf(unit_a_q[W-1], unit_b_q[W-1], UnitResult[W-1], unit_mode_q);

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         rsp_ovf_q <= 1'b0;
      end else if (capture) begin
         rsp_ovf_q <= rsp_ovf_d;
      end
   end

   assign RspOverflow = rsp_ovf_q;
`else
   assign RspOverflow = 1'b0;
`endif

   assign RspValid = rsp_valid_q;
   assign RspData  = rsp_data_q;
   assign UnitA    = unit_a_q;
   assign UnitB    = unit_b_q;
   assign UnitMode = unit_mode_q;

endmodule

// File: tb/tb_sign_add_sub_sched.sv
module tb_sign_add_sub_sched;

   localparam int W = 8;
   localparam int N = 4;
   localparam int L = 1;

`ifdef SIGN_ADD_SUB_SCHED_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic           Clk;
   logic           ResetN;
   logic [N-1:0]   ReqValid;
   logic [N-1:0]   ReqReady;
   logic [N*W-1:0] ReqA;
   logic [N*W-1:0] ReqB;
   logic [N-1:0]   ReqMode;
   logic [N-1:0]   RspValid;
   logic [N-1:0]   RspReady;
   logic [W-1:0]   RspData;
   logic           RspOverflow;
   logic [W-1:0]   UnitA;
   logic [W-1:0]   UnitB;
   logic           UnitMode;
   logic [W-1:0]   UnitResult;

   int n_checks = 0;
   int n_fail   = 0;

   sign_add_sub_sched #(
      .INPUT_BIT_WIDTH (W),
      .NUM_REQ         (N),
      .UNIT_LATENCY    (L)
   ) dut (
      .Clk         (Clk),
      .ResetN      (ResetN),
      .ReqValid    (ReqValid),
      .ReqReady    (ReqReady),
      .ReqA        (ReqA),
      .ReqB        (ReqB),
      .ReqMode     (ReqMode),
      .RspValid    (RspValid),
      .RspReady    (RspReady),
      .RspData     (RspData),
      .RspOverflow (RspOverflow),
      .UnitA       (UnitA),
      .UnitB       (UnitB),
      .UnitMode    (UnitMode),
      .UnitResult  (UnitResult)
   );

   // Behavioural shared unit, result valid one cycle after operands settle.
   assign UnitResult = UnitMode ? (UnitA - UnitB) : (UnitA + UnitB);

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      ReqA[i*W +: W] = a;
      ReqB[i*W +: W] = b;
      ReqMode[i]     = m;
   endtask

   // Called at a negedge in IDLE with requests already driven.
   task automatic do_op(input string tag, input logic [N-1:0] g,
                        input logic [W-1:0] d, input logic ovf);
      #1;
      chk({tag, "_accept"}, 32'(ReqReady), 32'(g));
      step(); #1;
      chk({tag, "_wait_ready"}, 32'(ReqReady), 32'(0));
      chk({tag, "_wait_rspv"}, 32'(RspValid), 32'(0));
      step(); #1;
      chk({tag, "_rspv"}, 32'(RspValid), 32'(g));
      chk({tag, "_data"}, 32'(RspData), 32'(d));
      chk({tag, "_ovf"}, 32'(RspOverflow), 32'(ovf));
      step();
   endtask

   initial begin
      ResetN   = 1'b0;
      ReqValid = '0;
      ReqA     = '0;
      ReqB     = '0;
      ReqMode  = '0;
      RspReady = '1;

      // Reset state, with requests asserted to show ReqReady stays low.
      @(negedge Clk);
      ReqValid = '1;
      #1;
      chk("rst_req_ready", 32'(ReqReady), 32'(0));
      chk("rst_rsp_valid", 32'(RspValid), 32'(0));
      chk("rst_rsp_data", 32'(RspData), 32'(0));
      chk("rst_rsp_ovf", 32'(RspOverflow), 32'(0));
      chk("rst_unit_a", 32'(UnitA), 32'(0));
      chk("rst_unit_b", 32'(UnitB), 32'(0));
      chk("rst_unit_mode", 32'(UnitMode), 32'(0));
      ReqValid = '0;
      @(negedge Clk);
      ResetN = 1'b1;
      @(negedge Clk);

      // 1. Single add on requester 0.
      set_req(0, 8'd20, 8'd8, 1'b0);
      ReqValid = 4'b0001;
      #1;
      chk("t1_accept", 32'(ReqReady), 32'(4'b0001));
      step();
      ReqValid = '0;
      #1;
      chk("t1_wait_ready", 32'(ReqReady), 32'(0));
      chk("t1_wait_rspv", 32'(RspValid), 32'(0));
      chk("t1_unit_a", 32'(UnitA), 32'(20));
      chk("t1_unit_b", 32'(UnitB), 32'(8));
      chk("t1_unit_mode", 32'(UnitMode), 32'(0));
      step(); #1;
      chk("t1_rspv", 32'(RspValid), 32'(4'b0001));
      chk("t1_data", 32'(RspData), 32'(28));
      chk("t1_ovf", 32'(RspOverflow), 32'(0));
      step(); #1;
      chk("t1_rspv_clear", 32'(RspValid), 32'(0));
      chk("t1_unit_a_hold", 32'(UnitA), 32'(20));

      // 2. Subtract to a negative result on requester 2 (pointer now 1).
      set_req(2, 8'd5, 8'd12, 1'b1);
      ReqValid = 4'b0100;
      do_op("t2", 4'b0100, 8'hF9, 1'b0);
      ReqValid = '0;

      // 3. Round-robin from a fresh reset: 0,1,3,0.
      ResetN = 1'b0;
      step();
      ResetN = 1'b1;
      step();
      set_req(0, 8'd1, 8'd2, 1'b0);
      set_req(1, 8'd10, 8'd3, 1'b1);
      set_req(3, 8'hFF, 8'hFF, 1'b0);
      ReqValid = 4'b1011;
      do_op("t3_op0", 4'b0001, 8'd3, 1'b0);
      do_op("t3_op1", 4'b0010, 8'd7, 1'b0);
      do_op("t3_op3", 4'b1000, 8'hFE, 1'b0);
      do_op("t3_op0b", 4'b0001, 8'd3, 1'b0);
      ReqValid = '0;

      // 4. Backpressure on requester 1 (pointer now 1); other RspReady lines high.
      set_req(1, 8'd3, 8'd4, 1'b0);
      RspReady = 4'b1101;
      ReqValid = 4'b0010;
      #1;
      chk("t4_accept", 32'(ReqReady), 32'(4'b0010));
      step();
      set_req(0, 8'd100, 8'd100, 1'b0);
      ReqValid = 4'b0001;
      #1;
      chk("t4_wait_ready", 32'(ReqReady), 32'(0));
      step();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold_rspv", 32'(RspValid), 32'(4'b0010));
         chk("t4_hold_data", 32'(RspData), 32'(7));
         chk("t4_hold_ready", 32'(ReqReady), 32'(0));
         step();
      end
      RspReady = '1;
      step(); #1;
      chk("t4_release_rspv", 32'(RspValid), 32'(0));
      chk("t4_next_accept", 32'(ReqReady), 32'(4'b0001));

      // 5. Overflow cases: 100+100 (accepted above), then -128-1.
      step();
      ReqValid = '0;
      #1;
      chk("t5a_wait_ready", 32'(ReqReady), 32'(0));
      step(); #1;
      chk("t5a_rspv", 32'(RspValid), 32'(4'b0001));
      chk("t5a_data", 32'(RspData), 32'(8'hC8));
      chk("t5a_ovf", 32'(RspOverflow), 32'(OVF_EN));
      step();
      set_req(0, 8'h80, 8'h01, 1'b1);
      ReqValid = 4'b0001;
      do_op("t5b", 4'b0001, 8'h7F, OVF_EN);
      ReqValid = '0;

      // 6. Reset while in WAIT (pointer now 1).
      set_req(2, 8'd1, 8'd1, 1'b0);
      ReqValid = 4'b0100;
      #1;
      chk("t6_accept", 32'(ReqReady), 32'(4'b0100));
      step();
      ReqValid = '0;
      #1;
      chk("t6_unit_a", 32'(UnitA), 32'(1));
      ResetN = 1'b0;
      #1;
      chk("t6_rst_unit_a", 32'(UnitA), 32'(0));
      chk("t6_rst_unit_b", 32'(UnitB), 32'(0));
      chk("t6_rst_rspv", 32'(RspValid), 32'(0));
      chk("t6_rst_data", 32'(RspData), 32'(0));
      step();
      step();
      ResetN = 1'b1;
      step(); #1;
      chk("t6_no_rsp0", 32'(RspValid), 32'(0));
      step(); #1;
      chk("t6_no_rsp1", 32'(RspValid), 32'(0));
      set_req(0, 8'd9, 8'd4, 1'b1);
      set_req(3, 8'd2, 8'd2, 1'b0);
      ReqValid = 4'b1001;
      do_op("t6_after", 4'b0001, 8'd5, 1'b0);
      ReqValid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sign_add_sub_sched.md
Name: sign_add_sub_sched

Overview:
- Round-robin scheduler that shares one signed add/sub datapath unit between N requesters.
- Accepts operand pairs and a mode bit over per-requester valid/ready handshakes, then drives the shared unit's InputA/InputB/AddSubMode.
- Waits a fixed unit latency, captures Result, and returns it to the granted requester with a response handshake.
- Sits between client blocks (e.g. filters and counters) and the single SignAddSub instance.

Parameters:
- INPUT_BIT_WIDTH, 8, operand/result width (two's complement).
- NUM_REQ, 4, number of requesters; must be at least 2.
- UNIT_LATENCY, 1, cycles from unit operands stable to unit Result valid; must be at least 1.

Ports:
- Clk  in  1  single clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- ReqValid  in  NUM_REQ  per-requester request valid.
- ReqReady  out  NUM_REQ  one-hot accept pulse.
- ReqA  in  NUM_REQ*INPUT_BIT_WIDTH  packed operand A; requester i in slice i.
- ReqB  in  NUM_REQ*INPUT_BIT_WIDTH  packed operand B.
- ReqMode  in  NUM_REQ  0=add (A+B), 1=sub (A-B).
- RspValid  out  NUM_REQ  one-hot response valid.
- RspReady  in  NUM_REQ  per-requester response accept.
- RspData  out  INPUT_BIT_WIDTH  signed result, shared bus.
- RspOverflow  out  1  signed overflow flag of RspData.
- UnitA  out  INPUT_BIT_WIDTH  to shared unit InputA.
- UnitB  out  INPUT_BIT_WIDTH  to shared unit InputB.
- UnitMode  out  1  to shared unit AddSubMode.
- UnitResult  in  INPUT_BIT_WIDTH  from shared unit Result.

Behaviour:
- Reset (ResetN low, asynchronous):
  - State=IDLE; priority pointer=0; grant index=0; wait counter=0.
  - All outputs 0: ReqReady, RspValid, RspData, RspOverflow, UnitA, UnitB, UnitMode.
  - Reset mid-operation drops the in-flight op; no response is produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Select the first asserted ReqValid searching pointer, pointer+1, ... modulo NUM_REQ.
  - If one is found: ReqReady[g]=1 combinationally in the same cycle (transfer = ReqValid&&ReqReady).
  - On that edge: latch slice g into UnitA/UnitB/UnitMode, store g, set counter=UNIT_LATENCY, go to WAIT.
  - If none is found, stay in IDLE.
- WAIT:
  - ReqReady=0 throughout.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: capture UnitResult into RspData, compute RspOverflow, go to RESP.
- RESP:
  - RspValid[g]=1; RspData and RspOverflow are held stable while waiting.
  - On RspValid[g]&&RspReady[g]: RspValid goes to 0, pointer=(g+1) mod NUM_REQ, go to IDLE.
  - RspReady on non-granted lines is ignored.
- Unit operands hold their values from IDLE accept until the next accept; they do not return to 0.
- Timing:
  - Minimum occupancy is UNIT_LATENCY+2 cycles per op with RspReady tied high.
  - Request-accept to RspValid is UNIT_LATENCY+1 cycles.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 other ops.
- A requester may drop ReqValid before it is granted; no state is kept for it.
- Arithmetic: wrap-around modulo 2^INPUT_BIT_WIDTH; no saturation.

Optional Feature:
- Macro: SIGN_ADD_SUB_SCHED_OVERFLOW_EN.
- Defined:
  - add: RspOverflow=1 when A and B have the same sign and the result sign differs.
  - sub: RspOverflow=1 when A and B signs differ and the result sign differs from A.
  - Computed from latched UnitA/UnitB/UnitMode and UnitResult at capture.
- Undefined: the RspOverflow port still exists, driven constant 0; no overflow logic is synthesised.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and mode constants (MODE_ADD=0, MODE_SUB=1).
- One sub-module, rr_pick_first:
  - Purely combinational round-robin finder.
  - Inputs: NUM_REQ request vector and pointer.
  - Outputs: found flag and index.
  - Reusable by other schedulers in the library.

Test Plan (NUM_REQ=4, INPUT_BIT_WIDTH=8, UNIT_LATENCY=1, behavioural unit model):
1. Single add: req0 A=20 B=8 mode=0, RspReady high -> ReqReady[0] in accept cycle, RspValid[0] 2 cycles later, RspData=28, RspOverflow=0.
2. Sub negative: req2 A=5 B=12 mode=1 -> RspData=-7 (0xF9), RspValid[2] only.
3. Round-robin: req0, req1, req3 held valid simultaneously from reset -> grant order 0,1,3,0; each request's data is correct.
4. Backpressure: req1 A=3 B=4 add, RspReady[1] low for 5 cycles -> RspValid[1] and RspData=7 held; no new ReqReady until the response handshake.
5. Overflow (macro defined): A=100 B=100 add -> RspData=-56, RspOverflow=1; A=-128 B=1 sub -> RspData=127, RspOverflow=1; macro undefined -> RspOverflow=0.
6. Reset in WAIT: assert ResetN low mid-op -> all outputs 0 immediately; no RspValid after release; the next request is granted from pointer 0.
